// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the boot-path blocks that sit between the
// program source and the CPU core.
//   loader_state_t : state encoding of the instruction-memory loader
//   INSTR_W        : width of one instruction word in bits
//   BYTES_PER_WORD : number of stream bytes packed into one instruction word
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } loader_state_t;

    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time program loader. Takes a byte stream over a valid/ready
// handshake, packs every four bytes little-endian into an instruction word
// and writes the words into instruction memory at consecutive word-aligned
// addresses starting at BASE_ADDR. The CPU is held out of execution until
// the requested number of words has been written.
//
// Ports:
//   Clk        : system clock, rising edge
//   Clrn       : synchronous active-high reset
//   Start      : one-cycle load request (honoured in IDLE, DONE, ERROR)
//   Word_count : number of words to load, sampled with Start
//   Byte_in    : stream data byte
//   Byte_valid : stream data valid
//   Byte_ready : loader accepts a byte this cycle
//   Imem_we    : instruction-memory write strobe, one cycle per word
//   Imem_addr  : word-aligned byte address of the write
//   Imem_wdata : packed instruction word
//   Busy       : load in progress
//   Done       : load completed, held until the next Start
//   Err        : load aborted by stream timeout, held until the next Start
//   Cpu_run    : CPU release, same as Done
import cpu_pkg::*;

module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 8,
    parameter int          TIMEOUT   = 1024,
    parameter int          TO_W      = 10
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic               Start,
    input  logic [CNT_W-1:0]   Word_count,
    input  logic [7:0]         Byte_in,
    input  logic               Byte_valid,
    output logic               Byte_ready,
    output logic               Imem_we,
    output logic [31:0]        Imem_addr,
    output logic [INSTR_W-1:0] Imem_wdata,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    output logic               Cpu_run
);

    localparam int BI_W = $clog2(BYTES_PER_WORD);
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES_PER_WORD - 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT - 1);

    loader_state_t      state_q;
    loader_state_t      state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   index_q;
    logic [CNT_W-1:0]   index_next;
    logic [BI_W-1:0]    byte_idx_q;
    logic [TO_W-1:0]    tcnt_q;
    logic [INSTR_W-1:0] wdata_q;
    logic               accept;
    logic               idle_like;

    // A byte is only ever taken while receiving; the other states hold
    // Byte_ready low so the source is back-pressured.
    assign accept     = Byte_valid && (state_q == RECV);
    assign index_next = index_q + 1'b1;
    assign idle_like  = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);

    // Next-state logic. The timeout only fires when no byte arrives on the
    // same edge, so a byte landing on the last allowed cycle still counts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (Start) begin
                    state_d = (Word_count == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (accept && (byte_idx_q == LAST_BYTE)) begin
                    state_d = WRITE;
                end else if (!accept && (tcnt_q == TO_LIMIT)) begin
                    state_d = ERROR;
                end
            end
            WRITE: begin
                state_d = (index_next == count_q) ? DONE : RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus the datapath: word count latch, word index,
    // byte index, idle-cycle counter and the word assembly register.
    always_ff @(posedge Clk) begin
        if (Clrn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            index_q    <= '0;
            byte_idx_q <= '0;
            tcnt_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (idle_like && Start) begin
                count_q    <= Word_count;
                index_q    <= '0;
                byte_idx_q <= '0;
                tcnt_q     <= '0;
            end
            if (state_q == RECV) begin
                if (accept) begin
                    wdata_q[{byte_idx_q, 3'b000} +: 8] <= Byte_in;
                    byte_idx_q <= byte_idx_q + 1'b1;
                    tcnt_q     <= '0;
                end else if (tcnt_q != TO_LIMIT) begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end
            if (state_q == WRITE) begin
                index_q <= index_next;
            end
        end
    end

    // Outputs are decoded from the state; the write address always tracks
    // the word index so it reads BASE_ADDR straight out of reset.
    assign Byte_ready = (state_q == RECV);
    assign Busy       = (state_q == RECV) || (state_q == WRITE);
    assign Imem_we    = (state_q == WRITE);
    assign Done       = (state_q == DONE);
    assign Err        = (state_q == ERROR);
    assign Cpu_run    = Done;
    assign Imem_addr  = BASE_ADDR + (32'(index_q) << 2);
    assign Imem_wdata = wdata_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the instruction memory and the CPU core.
- Accepts a byte stream over a valid/ready handshake and packs each 4 bytes into a little-endian 32-bit word.
- Writes each word into instruction memory at consecutive word-aligned addresses.
- Holds the CPU out of execution (Cpu_run low) until the whole program is loaded.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be a multiple of 4.
- CNT_W, 8, width of the word-count input and the internal word index.
- TIMEOUT, 1024, maximum idle cycles allowed between accepted bytes while receiving; must be at least 2.
- TO_W, 10, width of the timeout counter; 2^TO_W must be at least TIMEOUT.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Clrn  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle load request.
- Word_count  in  CNT_W  number of 32-bit words to load; sampled when Start is accepted.
- Byte_in  in  8  stream data.
- Byte_valid  in  1  stream data valid.
- Byte_ready  out  1  loader can accept a byte this cycle.
- Imem_we  out  1  instruction-memory write strobe, one cycle per word.
- Imem_addr  out  32  byte address of the write, word-aligned.
- Imem_wdata  out  32  packed instruction word.
- Busy  out  1  load in progress.
- Done  out  1  load completed successfully; held.
- Err  out  1  timeout abort; held.
- Cpu_run  out  1  CPU release; equals Done.

Behaviour:
- Reset: Clrn sampled high at a clock edge puts the block in IDLE. All outputs go to 0, Imem_addr becomes BASE_ADDR, and all counters and the assembly register clear.
  - Reset takes effect mid-load, abandons any partial word and issues no write.
- FSM states: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE, DONE and ERROR all react to Start the same way. Start=1 latches Word_count and clears the word index, byte index, timeout counter, Done and Err.
  - Word_count = 0: next state DONE (Done=1 the next cycle).
  - Otherwise: next state RECV.
- Start is ignored in RECV and WRITE.
- RECV:
  - Byte_ready=1 and Busy=1.
  - A byte is accepted when Byte_valid and Byte_ready are both high at an edge.
  - Byte k (k=0..3) goes into Imem_wdata[8k+7:8k].
  - Each accepted byte clears the timeout counter.
  - On the 4th byte: next state WRITE, and the byte index wraps to 0.
- WRITE:
  - Exactly one cycle with Imem_we=1, Byte_ready=0 and Busy=1.
  - Imem_addr = BASE_ADDR + 4*index, truncated to 32 bits.
  - Next edge: index increments. If the new index equals the latched count, go to DONE; otherwise go to RECV.
  - Imem_wdata is stable throughout WRITE.
- Timeout in RECV:
  - The counter increments on every cycle with no accepted byte.
  - When it reaches TIMEOUT-1 with no byte accepted on that edge, go to ERROR.
  - So ERROR is entered after TIMEOUT consecutive idle cycles.
  - If a byte is accepted on that same edge, the byte wins and the counter clears.
- DONE: Done=1, Cpu_run=1, Busy=0. Byte_ready=0, so extra bytes are back-pressured and not consumed.
- ERROR: Err=1, Cpu_run=0, Busy=0, no further writes.
- Latency: after the 4th byte of a word is accepted, Imem_we is asserted on the next cycle. Done rises the cycle after the last WRITE.
- Maximum throughput: one word per 5 cycles.
- Word index width is CNT_W. Count 2^CNT_W-1 is the largest load.

Decomposition:
- Shared package (cpu_pkg):
  - loader state enum (IDLE/RECV/WRITE/DONE/ERROR);
  - instruction word width constant (32);
  - bytes-per-word constant (4).
- No sub-module needed.
- Optional: the byte-to-word packer as a small sub-module named byte_packer (byte index, shift register and word-complete flag).

Test Plan:
- Reset with Clrn=1 for 2 cycles -> all outputs 0, Imem_addr=BASE_ADDR. Byte_valid=1 during reset is not accepted.
- Start, Word_count=2, bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 streamed back-to-back:
  - write 1: Imem_we at addr 0x0 with 0x0000_0013;
  - write 2: Imem_we at addr 0x4 with 0x0010_0093;
  - Done=Cpu_run=1 one cycle later;
  - 10 cycles total from Start.
- Word_count=0 -> Done=1 on the cycle after Start, no Imem_we.
- Start, Word_count=1, 2 bytes sent, then Byte_valid=0 for TIMEOUT cycles -> Err=1, Cpu_run=0, no Imem_we. A new Start clears Err.
- Byte_valid toggling 1/0 every cycle with Word_count=3 -> correct packing, addresses 0x0/0x4/0x8. Start pulses during RECV are ignored.
- Clrn=1 asserted after byte 3 of word 1 (Word_count=2) -> immediate IDLE, no write. A subsequent full load writes from BASE_ADDR.
